// File: rtl/cond_exec_ctrl.sv
// Conditional-execution issue controller: evaluates ARM condition codes, tracks in-flight flag writers.
// Optional build macro COND_FLAG_FWD_EN forwards ex_flags to the last pending writer's dependants.
module cond_exec_ctrl #(
  parameter int PEND_MAX = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       id_valid,
  input  logic [3:0] id_cond,
  input  logic       id_s,
  input  logic       ex_flag_valid,
  input  logic [3:0] ex_flags,
  input  logic       flush,
  output logic       id_stall,
  output logic       id_exec,
  output logic [3:0] sr,
  output logic [1:0] state
);

  // Handshake: an instruction held at issue with id_valid=1 is consumed in the first
  // cycle id_stall=0; id_exec then says whether it executed (condition passed).
  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    BUSY  = 2'b01,
    STALL = 2'b10
  } state_t;

  localparam logic [1:0] PEND_TOP = 2'(PEND_MAX);
  localparam logic [3:0] COND_AL  = 4'b1110;

  state_t     state_q, state_d;
  logic [1:0] pend_q, pend_d;
  logic [3:0] sr_q;
  logic [3:0] flags_used;
  logic       fwd;
  logic       stall_cond, stall_full;
  logic       inc, dec;

  function automatic logic cond_pass(input logic [3:0] cond, input logic [3:0] f);
    logic z, c, n, v;
    {z, c, n, v} = f;
    case (cond)
      4'b0000: return z;
      4'b0001: return ~z;
      4'b0010: return c;
      4'b0011: return ~c;
      4'b0100: return n;
      4'b0101: return ~n;
      4'b0110: return v;
      4'b0111: return ~v;
      4'b1000: return c & ~z;
      4'b1001: return ~c | z;
      4'b1010: return n == v;
      4'b1011: return n != v;
      4'b1100: return ~z & (n == v);
      4'b1101: return z | (n != v);
      4'b1110: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

`ifdef COND_FLAG_FWD_EN
  // The single outstanding writer is completing now: its flags are usable this cycle.
  assign fwd = (pend_q == 2'd1) & ex_flag_valid;
`else
  assign fwd = 1'b0;
`endif

  assign flags_used = fwd ? ex_flags : sr_q;

  assign stall_cond = id_valid & (id_cond != COND_AL) & (pend_q != 2'd0) & ~fwd;
  assign stall_full = id_valid & id_s & (pend_q == PEND_TOP) & ~ex_flag_valid;

  assign id_stall = ~flush & (stall_cond | stall_full);
  assign id_exec  = id_valid & ~id_stall & ~flush & cond_pass(id_cond, flags_used);

  assign inc = id_exec & id_s;
  assign dec = ex_flag_valid;

  always_comb begin
    pend_d  = pend_q;
    state_d = IDLE;
    if (flush) begin
      pend_d = 2'd0;
    end else if (inc && !dec) begin
      pend_d = pend_q + 2'd1;
    end else if (dec && !inc && pend_q != 2'd0) begin
      pend_d = pend_q - 2'd1;
    end
    if (flush) begin
      state_d = IDLE;
    end else if (id_stall) begin
      state_d = STALL;
    end else if (pend_d != 2'd0) begin
      state_d = BUSY;
    end else begin
      state_d = IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q  <= 2'd0;
      state_q <= IDLE;
      sr_q    <= 4'b0000;
    end else begin
      pend_q  <= pend_d;
      state_q <= state_d;
      if (ex_flag_valid) begin
        sr_q <= ex_flags;
      end
    end
  end

  assign sr    = sr_q;
  assign state = state_q;

endmodule

// File: tb/tb_cond_exec_ctrl.sv
// Bench for cond_exec_ctrl: directed vector table, reset corner, then random stimulus vs. a reference model.
// Honours COND_FLAG_FWD_EN the same way the design does.
module tb_cond_exec_ctrl;
  localparam int PEND_MAX = 2;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       id_valid;
  logic [3:0] id_cond;
  logic       id_s;
  logic       ex_flag_valid;
  logic [3:0] ex_flags;
  logic       flush;
  logic       id_stall;
  logic       id_exec;
  logic [3:0] sr;
  logic [1:0] state;

  cond_exec_ctrl #(.PEND_MAX(PEND_MAX)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_cond(id_cond), .id_s(id_s),
    .ex_flag_valid(ex_flag_valid), .ex_flags(ex_flags), .flush(flush),
    .id_stall(id_stall), .id_exec(id_exec), .sr(sr), .state(state)
  );

  // clock / reset
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  logic act_stall, act_exec;
  logic [5:0] exp_q[$];

  typedef struct {
    logic       v;
    logic [3:0] cond;
    logic       s;
    logic       efv;
    logic [3:0] f;
    logic       fl;
    logic       e_stall;
    logic       e_exec;
    logic [1:0] e_state;
    logic [3:0] e_sr;
  } vec_t;
  vec_t vq[$];

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic add(input logic v, input logic [3:0] c, input logic s, input logic efv,
                     input logic [3:0] f, input logic fl, input logic es, input logic ee,
                     input logic [1:0] est, input logic [3:0] esr);
    vec_t t;
    t = '{v, c, s, efv, f, fl, es, ee, est, esr};
    vq.push_back(t);
  endtask

  // driver: inputs change on the falling edge, combinational outputs sampled 1ns later
  task automatic apply(input logic v, input logic [3:0] c, input logic s, input logic efv,
                       input logic [3:0] f, input logic fl);
    @(negedge clk);
    id_valid = v; id_cond = c; id_s = s; ex_flag_valid = efv; ex_flags = f; flush = fl;
    #1;
    act_stall = id_stall;
    act_exec  = id_exec;
  endtask

  task automatic idle_inputs();
    id_valid = 1'b0; id_cond = 4'h0; id_s = 1'b0; ex_flag_valid = 1'b0; ex_flags = 4'h0; flush = 1'b0;
  endtask

  // reference condition check: codes come in complementary pairs selected by bit 0
  function automatic logic ref_pass(input logic [3:0] cond, input logic [3:0] f);
    logic z, c, n, v, b;
    z = f[3]; c = f[2]; n = f[1]; v = f[0];
    case (int'(cond[3:1]))
      0: b = z;
      1: b = c;
      2: b = n;
      3: b = v;
      4: b = c && !z;
      5: b = (n == v);
      6: b = !z && (n == v);
      default: b = 1'b1;
    endcase
    return cond[0] ? !b : b;
  endfunction

  int         m_pend;
  logic [3:0] m_sr;

  initial begin
    rst_n = 1'b0;
    idle_inputs();
    repeat (2) @(negedge clk);
    check("reset_sr", 8'(sr), 8'h0);
    check("reset_state", 8'(state), 8'h0);
    rst_n = 1'b1;

    // v cond s efv f fl | stall exec state sr
    add(1, 4'h0, 0, 0, 4'h0, 0, 0, 0, 2'd0, 4'h0);   // EQ on reset flags fails
    add(1, 4'hE, 1, 0, 4'h0, 0, 0, 1, 2'd1, 4'h0);   // AL flag setter -> pend 1
    add(1, 4'h0, 0, 0, 4'h0, 0, 1, 0, 2'd2, 4'h0);   // dependant stalls
`ifdef COND_FLAG_FWD_EN
    add(1, 4'h0, 0, 1, 4'h8, 0, 0, 1, 2'd0, 4'h8);   // forwarded z=1 issues now
`else
    add(1, 4'h0, 0, 1, 4'h8, 0, 1, 0, 2'd2, 4'h8);   // still stalled, sr written
`endif
    add(1, 4'h0, 0, 0, 4'h0, 0, 0, 1, 2'd0, 4'h8);
    add(0, 4'h0, 0, 1, 4'h3, 0, 0, 0, 2'd0, 4'h3);   // write with pend 0, no underflow
    add(1, 4'hA, 0, 0, 4'h0, 0, 0, 1, 2'd0, 4'h3);   // GE
    add(1, 4'hC, 0, 0, 4'h0, 0, 0, 1, 2'd0, 4'h3);   // GT
    add(1, 4'hD, 0, 0, 4'h0, 0, 0, 0, 2'd0, 4'h3);   // LE
    add(1, 4'hF, 0, 0, 4'h0, 0, 0, 0, 2'd0, 4'h3);   // never
    add(1, 4'hE, 1, 0, 4'h0, 0, 0, 1, 2'd1, 4'h3);   // pend 1
    add(1, 4'hE, 1, 0, 4'h0, 0, 0, 1, 2'd1, 4'h3);   // pend 2
    add(1, 4'hE, 1, 0, 4'h0, 0, 1, 0, 2'd2, 4'h3);   // full: stall
    add(1, 4'hE, 1, 1, 4'h4, 0, 0, 1, 2'd1, 4'h4);   // issues with write-back, pend stays 2
    add(1, 4'hE, 1, 1, 4'h2, 1, 0, 0, 2'd0, 4'h2);   // flush clears pend, sr still written
    add(1, 4'h1, 0, 0, 4'h0, 0, 0, 1, 2'd0, 4'h2);   // NE issues unstalled: pend is 0

    foreach (vq[i]) begin
      apply(vq[i].v, vq[i].cond, vq[i].s, vq[i].efv, vq[i].f, vq[i].fl);
      check($sformatf("vec%0d_stall", i), 8'(act_stall), 8'(vq[i].e_stall));
      check($sformatf("vec%0d_exec", i), 8'(act_exec), 8'(vq[i].e_exec));
      @(posedge clk); #1;
      check($sformatf("vec%0d_state", i), 8'(state), 8'(vq[i].e_state));
      check($sformatf("vec%0d_sr", i), 8'(sr), 8'(vq[i].e_sr));
    end

    // asynchronous reset with one writer pending
    apply(1, 4'hE, 1, 0, 4'h0, 0);
    @(posedge clk); #1;
    check("pre_rst_state", 8'(state), 8'h1);
    #1;
    rst_n = 1'b0;
    idle_inputs();
    #1;
    check("async_rst_sr", 8'(sr), 8'h0);
    check("async_rst_state", 8'(state), 8'h0);
    @(negedge clk);
    rst_n = 1'b1;
    apply(1, 4'h1, 0, 0, 4'h0, 0);
    check("post_rst_stall", 8'(act_stall), 8'h0);
    check("post_rst_exec", 8'(act_exec), 8'h1);
    @(posedge clk); #1;

    // random phase from a clean reset
    @(negedge clk);
    rst_n = 1'b0;
    idle_inputs();
    @(negedge clk);
    rst_n = 1'b1;
    m_pend = 0;
    m_sr   = 4'h0;
    for (int k = 0; k < 400; k++) begin
      logic v, s, efv, fl, fwd, e_stall, e_exec, inc;
      logic [3:0] c, f, flags;
      int n_pend, n_state;
      logic [5:0] got;
      v   = ($urandom_range(0, 3) != 0);
      c   = ($urandom_range(0, 2) == 0) ? 4'hE : 4'($urandom_range(0, 15));
      s   = 1'($urandom_range(0, 1));
      efv = ($urandom_range(0, 2) == 0);
      f   = 4'($urandom_range(0, 15));
      fl  = ($urandom_range(0, 19) == 0);
`ifdef COND_FLAG_FWD_EN
      fwd = (m_pend == 1) && efv;
`else
      fwd = 1'b0;
`endif
      flags   = fwd ? f : m_sr;
      e_stall = !fl && v && ((c != 4'hE && m_pend != 0 && !fwd) ||
                             (s && m_pend == PEND_MAX && !efv));
      e_exec  = v && !e_stall && !fl && ref_pass(c, flags);
      inc     = e_exec && s;
      if (fl) n_pend = 0;
      else if (inc && efv) n_pend = m_pend;
      else if (inc) n_pend = m_pend + 1;
      else if (efv) n_pend = (m_pend > 0) ? m_pend - 1 : 0;
      else n_pend = m_pend;
      if (fl) n_state = 0;
      else if (e_stall) n_state = 2;
      else n_state = (n_pend != 0) ? 1 : 0;
      exp_q.push_back({2'(n_state), efv ? f : m_sr});

      apply(v, c, s, efv, f, fl);
      check($sformatf("rnd%0d_stall", k), 8'(act_stall), 8'(e_stall));
      check($sformatf("rnd%0d_exec", k), 8'(act_exec), 8'(e_exec));
      @(posedge clk); #1;
      got = {state, sr};
      check($sformatf("rnd%0d_state_sr", k), 8'(got), 8'(exp_q.pop_front()));
      m_pend = n_pend;
      m_sr   = efv ? f : m_sr;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
